// File: rtl/echo_mix.sv
// Echo mixer: offset-binary dry + gain-scaled wet sample with a soft-mute gain ramp.
// Define ECHO_MIX_CLIP_EN to saturate the mix and drive the sticky clip flag; otherwise the sum wraps.
module echo_mix #(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned G_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] dry,
  input  logic [D_WIDTH-1:0] wet,
  input  logic [G_WIDTH-1:0] gain,
  input  logic               mute,
  input  logic               clip_clr,
  output logic [D_WIDTH-1:0] dout,
  output logic               valid,
  output logic               clip
);

  localparam int unsigned P_WIDTH = D_WIDTH + G_WIDTH + 1;
  localparam int unsigned S_WIDTH = D_WIDTH + 1;
  localparam logic [D_WIDTH-1:0] MIDSCALE = {1'b1, {(D_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ACTIVE, RAMP_DN, MUTED, RAMP_UP} state_t;

  state_t                    state_q;
  logic [G_WIDTH-1:0]        g_eff_q;
  logic signed [D_WIDTH-1:0] dry_s_q;
  logic signed [P_WIDTH-1:0] p_q;
  logic                      v1_q;
  logic [D_WIDTH-1:0]        dout_q;
  logic                      valid_q;
  logic                      clip_q;

  logic signed [D_WIDTH-1:0] dry_s_c;
  logic signed [D_WIDTH-1:0] wet_s_c;
  logic signed [P_WIDTH-1:0] wet_ext_c;
  logic signed [P_WIDTH-1:0] g_ext_c;
  logic signed [P_WIDTH-1:0] prod_c;
  logic signed [P_WIDTH-1:0] p_shift_c;
  logic signed [S_WIDTH-1:0] sum_c;
  logic signed [D_WIDTH-1:0] res_c;
  logic [G_WIDTH:0]          g_inc_c;
  logic [D_WIDTH-1:0]        dout_d;
  logic                      clip_d;

  // Offset-binary to two's complement is an MSB flip.
  assign dry_s_c   = signed'({~dry[D_WIDTH-1], dry[D_WIDTH-2:0]});
  assign wet_s_c   = signed'({~wet[D_WIDTH-1], wet[D_WIDTH-2:0]});
  assign wet_ext_c = P_WIDTH'(wet_s_c);
  assign g_ext_c   = signed'(P_WIDTH'(g_eff_q));
  assign prod_c    = wet_ext_c * g_ext_c;

  // Scaled wet always fits D_WIDTH bits, so the sum needs only one guard bit.
  assign p_shift_c = p_q >>> G_WIDTH;
  assign sum_c     = S_WIDTH'(dry_s_q) + S_WIDTH'(p_shift_c);
  assign g_inc_c   = {1'b0, g_eff_q} + (G_WIDTH+1)'(1);

`ifdef ECHO_MIX_CLIP_EN
  localparam logic signed [D_WIDTH-1:0] S_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [D_WIDTH-1:0] S_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};
  logic sat_c;

  assign sat_c  = sum_c[S_WIDTH-1] != sum_c[S_WIDTH-2];
  assign res_c  = sat_c ? (sum_c[S_WIDTH-1] ? S_MIN : S_MAX) : sum_c[D_WIDTH-1:0];
  assign clip_d = (v1_q & sat_c) | (clip_q & ~clip_clr);
`else
  logic unused_wrap;

  assign unused_wrap = ^{clip_clr, sum_c[S_WIDTH-1]};
  assign res_c  = sum_c[D_WIDTH-1:0];
  assign clip_d = 1'b0;
`endif

  assign dout_d = {~res_c[D_WIDTH-1], res_c[D_WIDTH-2:0]};

  // Two-stage datapath plus the gain-ramp FSM, all advanced by the sample strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ACTIVE;
      g_eff_q <= '0;
      dry_s_q <= '0;
      p_q     <= '0;
      v1_q    <= 1'b0;
      dout_q  <= MIDSCALE;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      v1_q    <= en;
      valid_q <= v1_q;
      clip_q  <= clip_d;
      if (v1_q) dout_q <= dout_d;
      if (en) begin
        dry_s_q <= dry_s_c;
        p_q     <= prod_c;
        unique case (state_q)
          ACTIVE: begin
            g_eff_q <= gain;
            if (mute) state_q <= RAMP_DN;
          end
          RAMP_DN: begin
            if (!mute) begin
              state_q <= RAMP_UP;
            end else if (g_eff_q <= G_WIDTH'(1)) begin
              g_eff_q <= '0;
              state_q <= MUTED;
            end else begin
              g_eff_q <= g_eff_q - G_WIDTH'(1);
            end
          end
          MUTED: begin
            g_eff_q <= '0;
            if (!mute) state_q <= RAMP_UP;
          end
          RAMP_UP: begin
            if (mute) begin
              state_q <= RAMP_DN;
            end else if (g_inc_c >= {1'b0, gain}) begin
              g_eff_q <= gain;
              state_q <= ACTIVE;
            end else begin
              g_eff_q <= g_inc_c[G_WIDTH-1:0];
            end
          end
          default: state_q <= ACTIVE;
        endcase
      end
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
  assign clip  = clip_q;

endmodule

// File: tb/tb_echo_mix.sv
// Scoreboard bench for echo_mix: directed samples push hand-computed results, a monitor pops on valid.
module tb_echo_mix;

`ifdef ECHO_MIX_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] dry;
  logic [7:0] wet;
  logic [3:0] gain;
  logic       mute;
  logic       clip_clr;
  logic [7:0] dout;
  logic       valid;
  logic       clip;

  typedef struct {
    logic [7:0]  dout;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          chk_on = 1'b0;
  logic [7:0]  hold_exp = 8'd128;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  echo_mix #(.D_WIDTH(8), .G_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .dry(dry), .wet(wet), .gain(gain),
    .mute(mute), .clip_clr(clip_clr), .dout(dout), .valid(valid), .clip(clip)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one sample for one strobe; queue the result for the active build.
  task automatic issue(input logic [7:0] d, input logic [7:0] w, input logic [3:0] g,
                       input logic m, input logic [7:0] e_clip, input logic [7:0] e_wrap);
    exp_t e;
    dry = d; wet = w; gain = g; mute = m; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    e.dout = CLIP_ON ? e_clip : e_wrap;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor: each valid must match the oldest expectation, one cycle after its strobe edge.
  always @(negedge clk) begin
    if (chk_on) begin
      if (valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("dout", dout, e.dout);
          check("valid_latency", cyc - e.cyc, 1);
          hold_exp = e.dout;
        end
      end else begin
        check("dout_hold", dout, hold_exp);
      end
    end
  end

  initial begin
    int seen;
    rst = 1'b0; en = 1'b0; dry = 8'd128; wet = 8'd128; gain = '0; mute = 1'b0; clip_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_dout", dout, 128);
    check("rst_valid", valid, 0);
    check("rst_clip", clip, 0);
    hold_exp = 8'd128;
    chk_on = 1'b1;

    // First strobe uses g_eff=0 from reset, then gain 8 settles.
    issue(128, 255, 8, 0, 128, 128);
    issue(128, 255, 8, 0, 191, 191);
    issue(128, 255, 8, 0, 191, 191);
    issue(128, 255, 8, 0, 191, 191);
    issue(128,   0, 8, 0,  64,  64);
    issue(255, 255, 15, 0, 255, 62);
    issue(255, 255, 15, 0, 255, 118);
    drain();
    check("clip_set", clip, CLIP_ON);
    idle(3);
    check("clip_sticky", clip, CLIP_ON);
    clip_clr = 1'b1;
    idle(1);
    clip_clr = 1'b0;
    check("clip_clr", clip, 0);

    // Saturation coinciding with clip_clr: set wins.
    clip_clr = 1'b1;
    issue(255, 255, 15, 0, 255, 118);
    idle(1);
    clip_clr = 1'b0;
    idle(1);
    check("clip_set_wins", clip, CLIP_ON);
    drain();

    // Mute ramp down 4->0, dry passes, then ramp up 0->4 with strobe gaps.
    issue(128, 255, 4, 0, 247, 247);
    issue(128, 255, 4, 1, 159, 159);
    issue(128, 255, 4, 1, 159, 159);
    issue(128, 255, 4, 1, 151, 151);
    issue(128, 255, 4, 1, 143, 143);
    issue(128, 255, 4, 1, 135, 135);
    issue(128, 255, 4, 1, 128, 128);
    issue(200, 255, 4, 1, 200, 200);
    issue(128, 255, 4, 0, 128, 128);
    issue(128, 255, 4, 0, 128, 128);
    issue(128, 255, 4, 0, 135, 135);
    issue(128, 255, 4, 0, 143, 143);
    idle(10);
    issue(128, 255, 4, 0, 151, 151);
    idle(10);
    issue(128, 255, 4, 0, 159, 159);
    issue( 37, 128, 4, 0,  37,  37);
    issue(250, 128, 4, 0, 250, 250);
    issue(255, 255, 4, 0, 255, 30);
    drain();
    check("clip_before_rst", clip, CLIP_ON);

    // Strobe immediately followed by reset: the in-flight sample must vanish.
    chk_on = 1'b0;
    dry = 8'd0; wet = 8'd0; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (valid) seen++;
    end
    check("valid_after_rst", seen, 0);
    check("dout_after_rst", dout, 128);
    check("clip_after_rst", clip, 0);
    hold_exp = 8'd128;
    #1;
    chk_on = 1'b1;

    // g_eff restarts at 0 after reset.
    issue(128, 255, 4, 0, 128, 128);
    issue(128, 255, 4, 0, 159, 159);
    drain();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/echo_mix.md
ECHO_MIX -- requirements
Module: echo_mix

Interface
REQ-001 Parameter D_WIDTH, default 8, sample width (unsigned offset-binary, midscale 2^(D_WIDTH-1)).
REQ-002 Parameter G_WIDTH, default 4, echo gain width; gain is a fraction g/2^G_WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  sample strobe, the same enable that advances the delay-line address counter.
REQ-006 dry  input  D_WIDTH  undelayed sample (the delay line's write data).
REQ-007 wet  input  D_WIDTH  delayed sample (the delay line's read data).
REQ-008 gain  input  G_WIDTH  requested echo gain.
REQ-009 mute  input  1  soft-mute request for the wet path only.
REQ-010 clip_clr  input  1  clears sticky clip flag.
REQ-011 dout  output  D_WIDTH  mixed sample, offset-binary.
REQ-012 valid  output  1  one-cycle pulse: dout updated this cycle.
REQ-013 clip  output  1  sticky saturation flag.

Function
REQ-014 Signed conversion: dry_s = dry - 2^(D_WIDTH-1), wet_s likewise (MSB inversion).
REQ-015 Stage 1, edge with en=1: register dry_s and p = wet_s * g_eff (D_WIDTH+G_WIDTH+1 bits signed), set v1; v1 cleared at edges with en=0.
REQ-016 Stage 2, edge with v1=1: sum = dry_s + (p >>> G_WIDTH) (arithmetic shift, floor), D_WIDTH+1 bits; dout = result + midscale; valid=1 next cycle only.
REQ-017 Latency exactly 2 clocks from en-sampling edge to valid; en every cycle yields valid every cycle; dout holds between valid pulses.
REQ-018 g_eff register (G_WIDTH bits) is the gain actually applied; stage 1 uses g_eff value before that edge's update.
REQ-019 FSM states ACTIVE, RAMP_DN, MUTED, RAMP_UP; transitions and g_eff updates occur only on edges with en=1.
REQ-020 ACTIVE: g_eff <= gain; mute=1 -> RAMP_DN.
REQ-021 RAMP_DN: g_eff decrements by 1; at g_eff==0 -> MUTED (no underflow); mute=0 -> RAMP_UP.
REQ-022 MUTED: g_eff=0; mute=0 -> RAMP_UP.
REQ-023 RAMP_UP: g_eff increments by 1; g_eff>=gain -> load gain, ACTIVE; mute=1 -> RAMP_DN (mute has priority).
REQ-024 Dry path is never muted or scaled.
REQ-025 clip: set on any stage-2 saturation event; clip_clr=1 clears; simultaneous set and clear -> set wins.

Reset
REQ-026 rst=0 at an edge: dout=midscale (128 at default), valid=0, clip=0, v1=0, g_eff=0, state ACTIVE; in-flight samples discarded, no valid for them.
REQ-027 Reset dominates en, mute, clip_clr.

Configuration
REQ-028 Macro ECHO_MIX_CLIP_EN defined: sum saturated to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1], clip behaves per REQ-025.
REQ-029 Macro ECHO_MIX_CLIP_EN undefined: sum truncated to D_WIDTH bits (two's-complement wrap), clip tied 0, clip_clr ignored.

Verification
REQ-030 dry=128, wet=255, gain=8, mute=0, en every cycle after 2 strobes settled -> dout=191, valid 2 clocks after each en.
REQ-031 dry=255, wet=255, gain=15 -> with ECHO_MIX_CLIP_EN dout=255, clip=1 and stays 1 until clip_clr; without it dout=118, clip=0.
REQ-032 dry=128, wet=0, gain=8 -> dout=64 (wet_s=-128, -1024>>>4=-64).
REQ-033 gain=4 in ACTIVE, assert mute -> g_eff 3,2,1,0 on successive en edges, state MUTED; release mute -> g_eff 1,2,3,4, state ACTIVE; dry-only samples pass unchanged throughout.
REQ-034 Single en pulse then rst=0 on next edge -> valid never asserts, dout=128, clip=0.
REQ-035 en low for 10 cycles between strobes -> exactly one valid per strobe, dout and g_eff unchanged while en low.
